// File: rtl/bit_deserializer.sv
// rtl/bit_deserializer.sv - serial frame receiver with output word FIFO
//
// Purpose: receives framed words from a one-bit-per-cycle stream and queues
// them in a small FIFO for a valid/ready consumer.
// Frame on io_in: start bit (1), WIDTH data bits LSB first, stop bit (0).
// With PARITY_CHECK_EN defined, an even-parity bit sits between the last
// data bit and the stop bit.
//
// Ports:
//   clk          - sole clock, rising edge
//   reset        - synchronous, active-high
//   io_in        - serial input, idle level 0
//   io_out_valid - FIFO head holds a received word
//   io_out_ready - consumer accepts the head word
//   io_out_bits  - head word, bit 0 = first data bit received
//   io_frame_err - one-cycle pulse: frame dropped (bad stop or parity bit)
//   io_overrun   - one-cycle pulse: good frame dropped, FIFO full
//
// Macro: PARITY_CHECK_EN adds the parity bit and its check.

module bit_deserializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_in,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_bits,
    output logic             io_frame_err,
    output logic             io_overrun
);

    localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;
`endif

    state_t            state_q, state_d;
    logic              bit_q, bit_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
`ifdef PARITY_CHECK_EN
    logic              par_ok_q, par_ok_d;
`endif

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic              push;
    logic              pop;
    logic              full;
    logic              frame_good;

    assign full = (count_q == CW'(DEPTH));
    assign pop  = (count_q != '0) && io_out_ready;

    // Receive FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        push        = 1'b0;
        frame_good  = 1'b0;
`ifdef PARITY_CHECK_EN
        par_ok_d    = par_ok_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bit_q) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CNTW'(i)) begin
                        shreg_d[i] = bit_q;
                    end
                end
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                // Even parity over data plus parity bit
                par_ok_d = ~((^shreg_q) ^ bit_q);
                state_d  = STOP;
            end
`endif
            STOP: begin
`ifdef PARITY_CHECK_EN
                frame_good = ~bit_q & par_ok_q;
`else
                frame_good = ~bit_q;
`endif
                if (frame_good) begin
                    // A pop at the same edge frees the slot being written
                    if (!full || pop) begin
                        push = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    frame_err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output FIFO
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        bit_d    = io_in;

        if (push) begin
            mem_d[wr_ptr_q] = shreg_q;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_q       <= 1'b0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_ok_q    <= 1'b0;
`endif
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef PARITY_CHECK_EN
            par_ok_q    <= par_ok_d;
`endif
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
        end
    end

    assign io_out_valid = (count_q != '0);
    assign io_out_bits  = mem_q[rd_ptr_q];
    assign io_frame_err = frame_err_q;
    assign io_overrun   = overrun_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// tb/tb_bit_deserializer.sv - directed-vector bench for bit_deserializer

module tb_bit_deserializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       io_in;
    logic       io_out_valid;
    logic       io_out_ready;
    logic [7:0] io_out_bits;
    logic       io_frame_err;
    logic       io_overrun;

    int n_vec = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic both_seen = 1'b0;

`ifdef PARITY_CHECK_EN
    localparam int EXP_FE = 2;
`else
    localparam int EXP_FE = 1;
`endif

    bit_deserializer #(.WIDTH(8), .DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_in        (io_in),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_bits  (io_out_bits),
        .io_frame_err (io_frame_err),
        .io_overrun   (io_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (io_frame_err) fe_cnt <= fe_cnt + 1;
        if (io_overrun)   ov_cnt <= ov_cnt + 1;
        if (io_frame_err && io_overrun) both_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        io_in = b;
        tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef PARITY_CHECK_EN
        send_bit(par);
`endif
        send_bit(stp);
        io_in = 1'b0;
    endtask

    initial begin
        int fe0;
        int ov0;
        reset        = 1'b1;
        io_in        = 1'b1;
        io_out_ready = 1'b0;
        tick(); tick(); tick();
        chk("rst_valid", io_out_valid, 0);
        chk("rst_bits",  io_out_bits,  0);
        chk("rst_ferr",  io_frame_err, 0);
        chk("rst_ovr",   io_overrun,   0);

        // start bit held high across reset release must not start a frame
        reset = 1'b0;
        io_in = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("rel_start_ignored", io_out_valid, 0);
        chk("rel_no_ferr", fe_cnt, 0);

        // 0xA5 with ready high: visible exactly at the push edge, popped next
        io_out_ready = 1'b1;
        send_frame(8'hA5, ^8'hA5, 1'b0);
        chk("a5_before_push", io_out_valid, 0);
        tick();
        chk("a5_valid", io_out_valid, 1);
        chk("a5_bits",  io_out_bits, 8'hA5);
        tick();
        chk("a5_one_pop", io_out_valid, 0);
        io_out_ready = 1'b0;

        // bad stop bit on 0x3C, then 0x81 good
        send_frame(8'h3C, ^8'h3C, 1'b1);
        tick();
        chk("3c_ferr", io_frame_err, 1);
        chk("3c_no_valid", io_out_valid, 0);
        tick();
        chk("3c_ferr_pulse", io_frame_err, 0);
        send_frame(8'h81, ^8'h81, 1'b0);
        tick();
        chk("81_valid", io_out_valid, 1);
        chk("81_bits",  io_out_bits, 8'h81);
        io_out_ready = 1'b1;
        tick();
        io_out_ready = 1'b0;
        chk("81_popped", io_out_valid, 0);

        // three frames into a two-entry FIFO, no consumer
        send_frame(8'h11, ^8'h11, 1'b0);
        send_frame(8'h22, ^8'h22, 1'b0);
        send_frame(8'h33, ^8'h33, 1'b0);
        chk("ovr_before", io_overrun, 0);
        tick();
        chk("ovr_pulse", io_overrun, 1);
        chk("ovr_head",  io_out_bits, 8'h11);
        tick();
        chk("ovr_one_cycle", io_overrun, 0);
        tick(); tick();
        chk("head_stable", io_out_bits, 8'h11);
        io_out_ready = 1'b1;
        tick();
        chk("ovr_pop2", io_out_bits, 8'h22);
        chk("ovr_pop2_v", io_out_valid, 1);
        tick();
        chk("ovr_drained", io_out_valid, 0);
        io_out_ready = 1'b0;

        // full FIFO, pop in the same cycle as the third push
        send_frame(8'h11, ^8'h11, 1'b0);
        send_frame(8'h22, ^8'h22, 1'b0);
        send_frame(8'h33, ^8'h33, 1'b0);
        chk("full_head", io_out_bits, 8'h11);
        io_out_ready = 1'b1;
        tick();
        chk("full_no_ovr", io_overrun, 0);
        chk("full_pop_22", io_out_bits, 8'h22);
        tick();
        chk("full_pop_33", io_out_bits, 8'h33);
        chk("full_pop_33_v", io_out_valid, 1);
        tick();
        chk("full_drained", io_out_valid, 0);
        io_out_ready = 1'b0;

        // reset mid-frame after four data bits
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        io_in = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("mid_rst_no_push", io_out_valid, 0);
        chk("mid_rst_no_ferr", fe_cnt - fe0, 0);
        chk("mid_rst_no_ovr",  ov_cnt - ov0, 0);
        send_frame(8'h5A, ^8'h5A, 1'b0);
        tick();
        chk("5a_valid", io_out_valid, 1);
        chk("5a_bits",  io_out_bits, 8'h5A);
        io_out_ready = 1'b1;
        tick();
        io_out_ready = 1'b0;
        chk("5a_popped", io_out_valid, 0);

`ifdef PARITY_CHECK_EN
        send_frame(8'h07, 1'b1, 1'b0);
        tick();
        chk("par_good_valid", io_out_valid, 1);
        chk("par_good_bits",  io_out_bits, 8'h07);
        io_out_ready = 1'b1;
        tick();
        io_out_ready = 1'b0;
        send_frame(8'h07, 1'b0, 1'b0);
        tick();
        chk("par_bad_ferr", io_frame_err, 1);
        chk("par_bad_no_push", io_out_valid, 0);
        tick();
`endif

        tick();
        chk("ferr_total", fe_cnt, EXP_FE);
        chk("ovr_total",  ov_cnt, 1);
        chk("ferr_ovr_excl", both_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bit_deserializer.md
BIT_DESERIALIZER -- requirements
Module: bit_deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data bits per frame, legal range 1..32.
REQ-002 The block SHALL have parameter DEPTH, default 2: output FIFO entries, legal range 1..8.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port io_in  input  1  serial bit stream, one bit per clk cycle, idle level 0.
REQ-006 The block SHALL have port io_out_valid  output  1  FIFO head holds a received word.
REQ-007 The block SHALL have port io_out_ready  input  1  consumer accepts the head word.
REQ-008 The block SHALL have port io_out_bits  output  WIDTH  head word; bit 0 is the first data bit received.
REQ-009 The block SHALL have port io_frame_err  output  1  one-cycle pulse when a frame is dropped for a bad stop bit (or bad parity, REQ-031).
REQ-010 The block SHALL have port io_overrun  output  1  one-cycle pulse when a good frame is dropped because the FIFO is full.

Function
REQ-011 io_in SHALL pass through one input register stage (bit_q) before reaching any other logic.
REQ-012 Frame format SHALL be: start bit 1, then WIDTH data bits LSB first, then stop bit 0.
REQ-013 The FSM SHALL have states IDLE, DATA and STOP.
REQ-014 IDLE -> DATA when bit_q=1; the data bit counter SHALL clear to 0 on this transition.
REQ-015 In DATA, each cycle SHALL shift bit_q into shift-register position cnt and increment cnt; after the last data bit (cnt=WIDTH-1) the FSM SHALL go to STOP.
REQ-016 In STOP, bit_q=0 SHALL push the shift register into the FIFO; bit_q=1 SHALL drop the frame and pulse io_frame_err; either way the FSM SHALL return to IDLE.
REQ-017 Timing: with the start bit on io_in at edge k, the push SHALL occur at edge k+WIDTH+2, and io_out_valid SHALL be 1 from that edge onward.
REQ-018 Back-to-back frames SHALL be accepted: a start bit at the edge right after the stop bit SHALL be recognised.
REQ-019 A pop SHALL occur at a rising edge where io_out_valid=1 and io_out_ready=1.
REQ-020 io_out_bits SHALL be stable while io_out_valid=1 and no pop occurs.
REQ-021 A push into a full FIFO in the same cycle as a pop SHALL succeed without io_overrun.
REQ-022 A push into a full FIFO with no pop in that cycle SHALL drop the frame, pulse io_overrun, and leave the FIFO contents unchanged.
REQ-023 A push and a pop in the same cycle on a non-full FIFO SHALL leave the occupancy unchanged.
REQ-024 FIFO read and write pointers SHALL wrap modulo DEPTH, and a separate occupancy count (0..DEPTH) SHALL distinguish full from empty.
REQ-025 io_frame_err and io_overrun SHALL never both be 1 in the same cycle.

Reset
REQ-026 While reset=1 at an edge: FSM -> IDLE, bit_q=0, cnt=0, FIFO empty with pointers 0.
REQ-027 Reset values SHALL be io_out_valid=0, io_out_bits=0, io_frame_err=0, io_overrun=0.
REQ-028 Reset during DATA or STOP SHALL abandon the partial frame without pushing it and without any error pulse.
REQ-029 A start bit present on io_in in the same cycle reset is released SHALL be ignored, because bit_q is held at 0 during reset.

Configuration
REQ-030 Macro PARITY_CHECK_EN SHALL control parity checking.
REQ-031 With PARITY_CHECK_EN defined: a parity bit SHALL follow the data bits (new state PARITY between DATA and STOP), valid frames SHALL have even parity over data plus parity bit, and bad parity or a bad stop bit SHALL drop the frame with a single io_frame_err pulse in the STOP cycle; push latency SHALL be k+WIDTH+3.
REQ-032 Without PARITY_CHECK_EN: no PARITY state, frame format per REQ-012, latency per REQ-017.

Verification
REQ-033 WIDTH=8, io_out_ready=1, serial 1,1,0,1,0,0,1,0,1,0 -> io_out_bits=0xA5 with io_out_valid=1 at edge k+10, and exactly one pop.
REQ-034 Stop bit forced to 1 on a 0x3C frame -> io_frame_err=1 for one cycle, io_out_valid remains 0, and the next 0x81 frame is received correctly.
REQ-035 DEPTH=2, io_out_ready=0, three back-to-back frames 0x11, 0x22, 0x33 -> io_overrun pulses once, at the third push edge; after raising ready, pops return 0x11 then 0x22 only.
REQ-036 FIFO full with ready raised in the cycle of the third push -> no overrun; pops return 0x11, 0x22, 0x33 in order.
REQ-037 reset asserted for one cycle mid-frame after 4 data bits -> no push and no pulse; a complete frame 0x5A sent afterwards is received as 0x5A.
REQ-038 PARITY_CHECK_EN defined, data 0x07 with parity bit 1 -> received 0x07; same frame with parity bit 0 -> io_frame_err pulse and no push.
